// File: rtl/id_authentication_if.sv
// ----------------------------------------------------------------------------
// id_authentication_if
// Purpose : Bundles the signals between the ID-entry stage, its keypad/switch
//           source, the user-ID ROM and the password stage.
// Signals :
//   UserLoad             keypad -> id stage, one-cycle "latch digit" pulse
//   UserDigit[3:0]       keypad -> id stage, digit value
//   logout               password stage -> id stage, clears the session
//   logout_from_gamectrl game control -> id stage, clears the session
//   addr[2:0]            id stage -> ROM, registered read address
//   data_rom_ID[15:0]    ROM -> id stage, read data one cycle after addr
//   matchedID            id stage -> password stage, ID accepted (held)
//   ID_internal[2:0]     id stage -> password stage, matched ROM index
//   isGuest              id stage -> password stage, guest login (held)
//   IDFailLED            id stage -> LED, last attempt failed (held)
// Modports: master = keypad/ROM/password side, slave = id_authentication.
// ----------------------------------------------------------------------------
interface id_authentication_if;
  logic        UserLoad;
  logic [3:0]  UserDigit;
  logic        logout;
  logic        logout_from_gamectrl;
  logic [2:0]  addr;
  logic [15:0] data_rom_ID;
  logic        matchedID;
  logic [2:0]  ID_internal;
  logic        isGuest;
  logic        IDFailLED;

  modport master (
    output UserLoad, UserDigit, logout, logout_from_gamectrl, data_rom_ID,
    input  addr, matchedID, ID_internal, isGuest, IDFailLED
  );

  modport slave (
    input  UserLoad, UserDigit, logout, logout_from_gamectrl, data_rom_ID,
    output addr, matchedID, ID_internal, isGuest, IDFailLED
  );
endinterface

// File: rtl/id_authentication.sv
// ----------------------------------------------------------------------------
// id_authentication
// Purpose : Collects a 4-digit user ID, then scans the synchronous user-ID
//           ROM entry by entry. On a hit (or the guest ID) it raises
//           matchedID with the ROM index / guest flag and holds them until
//           a logout. A full scan without a hit lights IDFailLED.
// Ports   :
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - id_authentication_if.slave (digit input, ROM port, results)
// Parameters:
//   NUM_IDS  - ROM entries scanned (1..8)
//   GUEST_ID - ID that logs in as guest without a ROM lookup
//   EMPTY_ID - ROM content marking an unused slot (never matches)
// ----------------------------------------------------------------------------
module id_authentication #(
  parameter int unsigned NUM_IDS  = 8,
  parameter logic [15:0] GUEST_ID = 16'h0000,
  parameter logic [15:0] EMPTY_ID = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  id_authentication_if.slave bus
);

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    FETCH   = 2'd1,
    COMPARE = 2'd2,
    MATCHED = 2'd3
  } state_t;

  localparam logic [2:0] LAST_ADDR = 3'(NUM_IDS - 1);

  // Registered state
  state_t      r_state;
  logic [1:0]  r_count;
  logic [15:0] r_id;
  logic [2:0]  r_addr;
  logic        r_matched;
  logic [2:0]  r_id_internal;
  logic        r_is_guest;
  logic        r_fail;

  // Next-state values
  state_t      w_state_nxt;
  logic [1:0]  w_count_nxt;
  logic [15:0] w_id_nxt;
  logic [2:0]  w_addr_nxt;
  logic        w_matched_nxt;
  logic [2:0]  w_id_internal_nxt;
  logic        w_is_guest_nxt;
  logic        w_fail_nxt;

  logic        w_logout;
  logic [15:0] w_id_shift;
  logic        w_rom_hit;

  assign w_logout   = bus.logout | bus.logout_from_gamectrl;
  // The digit being loaded now is part of the ID compared on the 4th load.
  assign w_id_shift = {r_id[11:0], bus.UserDigit};
  assign w_rom_hit  = (bus.data_rom_ID == r_id) && (bus.data_rom_ID != EMPTY_ID);

  // NOTE: every next-state signal gets a hold default before the case
  // statement, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt       = r_state;
    w_count_nxt       = r_count;
    w_id_nxt          = r_id;
    w_addr_nxt        = r_addr;
    w_matched_nxt     = r_matched;
    w_id_internal_nxt = r_id_internal;
    w_is_guest_nxt    = r_is_guest;
    w_fail_nxt        = r_fail;

    if (w_logout) begin
      // Logout wins over a digit load or a COMPARE result in the same cycle;
      // the fail LED keeps showing the outcome of the last attempt.
      w_state_nxt       = ENTRY;
      w_count_nxt       = 2'd0;
      w_id_nxt          = 16'h0000;
      w_addr_nxt        = 3'd0;
      w_matched_nxt     = 1'b0;
      w_id_internal_nxt = 3'd0;
      w_is_guest_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        ENTRY: begin
          if (bus.UserLoad) begin
            w_id_nxt = w_id_shift;
            if (r_count == 2'd0) begin
              w_fail_nxt = 1'b0;
            end
            if (r_count == 2'd3) begin
              w_count_nxt = 2'd0;
              if (w_id_shift == GUEST_ID) begin
                w_state_nxt       = MATCHED;
                w_matched_nxt     = 1'b1;
                w_is_guest_nxt    = 1'b1;
                w_id_internal_nxt = 3'd0;
              end else begin
                w_addr_nxt  = 3'd0;
                w_state_nxt = FETCH;
              end
            end else begin
              w_count_nxt = r_count + 2'd1;
            end
          end
        end

        // ROM data for r_addr is valid one cycle after the address changes.
        FETCH: w_state_nxt = COMPARE;

        COMPARE: begin
          if (w_rom_hit) begin
            w_state_nxt       = MATCHED;
            w_matched_nxt     = 1'b1;
            w_id_internal_nxt = r_addr;
            w_is_guest_nxt    = 1'b0;
          end else if (r_addr == LAST_ADDR) begin
            w_state_nxt = ENTRY;
            w_fail_nxt  = 1'b1;
            w_id_nxt    = 16'h0000;
          end else begin
            w_addr_nxt  = r_addr + 3'd1;
            w_state_nxt = FETCH;
          end
        end

        // Results held; further digits belong to the password stage.
        MATCHED: ;

        default: w_state_nxt = ENTRY;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ENTRY;
      r_count       <= 2'd0;
      r_id          <= 16'h0000;
      r_addr        <= 3'd0;
      r_matched     <= 1'b0;
      r_id_internal <= 3'd0;
      r_is_guest    <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_id          <= w_id_nxt;
      r_addr        <= w_addr_nxt;
      r_matched     <= w_matched_nxt;
      r_id_internal <= w_id_internal_nxt;
      r_is_guest    <= w_is_guest_nxt;
      r_fail        <= w_fail_nxt;
    end
  end

  // All outputs come straight from registers.
  assign bus.addr        = r_addr;
  assign bus.matchedID   = r_matched;
  assign bus.ID_internal = r_id_internal;
  assign bus.isGuest     = r_is_guest;
  assign bus.IDFailLED   = r_fail;

endmodule

// File: doc/id_authentication.md
# id_authentication

First stage of the login chain. It collects a 4-digit user ID from the debounced keypad/switch path and looks it up in the user ID ROM by a sequential scan. On a hit it asserts `matchedID` with the 3-bit internal player index and a guest flag. These outputs feed the password-authentication stage directly, and the block holds them until a logout.

## Interface
- `NUM_IDS`, default 8: number of ROM entries scanned, 1..8.
- `GUEST_ID`, default 16'h0000: 4-digit ID that logs in as guest without a ROM lookup.
- `EMPTY_ID`, default 16'hFFFF: ROM content marking an unused slot; such a slot never matches.

Ports:
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `UserLoad`, input, 1: one-cycle pulse meaning "latch `UserDigit`".
- `UserDigit`, input, 4: digit value, sampled when `UserLoad`=1.
- `logout`, input, 1: level or pulse from the password stage; clears the session.
- `logout_from_gamectrl`, input, 1: same effect as `logout`.
- `addr`, output, 3: ID ROM address, registered.
- `data_rom_ID`, input, 16: ID ROM read data, valid one cycle after `addr` changes (synchronous ROM).
- `matchedID`, output, 1: ID accepted; held.
- `ID_internal`, output, 3: matched ROM index; 3'd0 for a guest.
- `isGuest`, output, 1: the guest ID was entered; held with `matchedID`.
- `IDFailLED`, output, 1: last attempt failed; held.

## Operation
- States: ENTRY, FETCH, COMPARE, MATCHED.
- **Reset (async):** state=ENTRY; digit count=0; ID shift register=0; `addr`=0; `matchedID`=0; `ID_internal`=0; `isGuest`=0; `IDFailLED`=0.
- **ENTRY**
  - Each `UserLoad` shifts `UserDigit` into a 16-bit register, MSB digit first: `id <= {id[11:0], UserDigit}`. The count increments.
  - The first `UserLoad` of an attempt clears `IDFailLED`.
  - Digit values 10..15 are accepted unchanged.
- **On the 4th digit**
  - The count resets to 0.
  - If the full ID (including this digit) equals `GUEST_ID`, go to MATCHED with `isGuest`=1 and `ID_internal`=0. No ROM access.
  - Otherwise `addr` is set to 0 and the state goes to FETCH.
- **FETCH:** one wait cycle for ROM latency, then COMPARE.
- **COMPARE**
  - If `data_rom_ID` == ID and `data_rom_ID` != `EMPTY_ID`: go to MATCHED, `ID_internal`=`addr`, `isGuest`=0.
  - Else if `addr` == `NUM_IDS`-1: `IDFailLED`=1, clear the ID register, go to ENTRY.
  - Else `addr`=`addr`+1 and go to FETCH.
- **MATCHED:** `matchedID`=1 and is held. `UserLoad` is ignored; digits are consumed by the password stage.
- **Logout:** (`logout` | `logout_from_gamectrl`) in any state other than reset does the following next edge:
  - state=ENTRY; `matchedID`=0, `isGuest`=0, `ID_internal`=0, `addr`=0.
  - Count=0 and ID register=0.
  - `IDFailLED` is unchanged.
  - Logout has priority over `UserLoad` and over a COMPARE result in the same cycle.
- The first matching ROM entry wins. Duplicate IDs resolve to the lowest index.

## Timing
- The `UserLoad` edge for digit 4 is edge T0. Guest: `matchedID`=1 after T0.
- ROM path: `addr`=0 after T0. The COMPARE for entry k happens at edge T0+2(k+1).
- On a match at entry k, `matchedID` is high after edge T0+2(k+1).
- Worst-case fail: `IDFailLED` high after edge T0+2·`NUM_IDS` (16 cycles for 8 entries).
- `UserLoad` during FETCH/COMPARE is dropped and does not count toward the next attempt.
- Outputs are registered, with no combinational path from inputs. `addr` is stable for the full FETCH+COMPARE pair.
- Reset asserted mid-scan aborts immediately. Outputs return to reset values asynchronously.

## Test plan
- **ROM match.** ROM {0:1234, 3:3848, others FFFF}. Enter 3,8,4,8 → `addr` steps 0..3; `matchedID`=1 and `ID_internal`=3 eight cycles after the 4th `UserLoad`; `isGuest`=0.
- **Guest.** Enter 0,0,0,0 → `matchedID`=1, `isGuest`=1, `ID_internal`=0 one cycle after the 4th `UserLoad`; `addr` stays 0.
- **Fail, then recover.** Enter 5,5,5,5 → all 8 entries scanned, `IDFailLED`=1 after 16 cycles, `matchedID`=0. Next `UserLoad` (digit 1) → `IDFailLED`=0. Completing 1,2,3,4 then matches with `ID_internal`=0.
- **Input ignored while busy or matched.** `UserLoad` pulses during the scan and in MATCHED → no shift-register change; the result is unaffected.
- **Logout.**
  - `logout_from_gamectrl` pulse while MATCHED → `matchedID`/`isGuest`/`ID_internal` return to 0 next edge.
  - Logout asserted in the same cycle as a matching COMPARE → stays in ENTRY with `matchedID`=0.
- **Reset.**
  - `rst` asserted mid-scan (`addr`=2) → all outputs at reset values without a clock edge.
  - After release, a partial entry of 2 digits followed by `rst` → a fresh 4 digits are required.
  - Empty-slot check: entering F,F,F,F with unused slots at FFFF → fail.
